letter2spike: RTL



---
 rtl/l2s_pkg.sv | 22 ++
 rtl/l2s_lfsr16.sv | 33 +++
 rtl/letter2spike.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/l2s_pkg.sv
// l2s_pkg: shared FSM type and constants for the letter2spike framebuffer scanner.
package l2s_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StWait,
      StEmit
   } l2s_state_e;

   // Mid-gray level; subtracting it centres the current around zero.
   localparam logic [8:0]  GRAY_BIAS         = 9'd128;
   // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   // All-zero is the LFSR lock-up state, so substitute a legal one.
   function automatic logic [15:0] lfsr_fix_seed(input logic [15:0] seed);
      return (seed == 16'h0000) ? 16'h0001 : seed;
   endfunction

endpackage

// File: rtl/l2s_lfsr16.sv
// l2s_lfsr16: 16-bit Fibonacci LFSR that steps only when adv is high.
module l2s_lfsr16
   import l2s_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] seed,
   input  logic        adv,
   output logic [15:0] q
);

   logic [15:0] q_q, q_d;

   // Next state: shift left, feed back the parity of the tapped bits.
   always_comb begin
      q_d = q_q;
      if (adv) begin
         q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
      end
   end

   // State register; reset reloads the (zero-protected) seed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= lfsr_fix_seed(seed);
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/letter2spike.sv
// letter2spike: scans an 8-bit grayscale framebuffer one neuron per record and emits a
// rate-coded spike bit plus a signed fixed-point input current for each neuron.
// Define L2S_THRESHOLD_MODE_EN to replace the LFSR rate code with spike = (gray >= 128);
// the LFSR is then not instantiated.
// WIDTH must be at least 9 and FRAC at least 4.
module letter2spike
   import l2s_pkg::*;
#(
   parameter int unsigned WIDTH             = 32,
   parameter int unsigned FRAC              = 16,
   parameter int unsigned NEURON_ADDR_WIDTH = 8,
   parameter int unsigned NUM_NEURONS       = 256,
   parameter logic [15:0] LFSR_SEED         = LFSR_DEFAULT_SEED
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic                         fb_re,
   output logic [NEURON_ADDR_WIDTH-1:0] fb_addr,
   input  logic [7:0]                   fb_rdata,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         spike_valid,
   output logic [NEURON_ADDR_WIDTH-1:0] neuron_idx,
   output logic [WIDTH-1:0]             i_out,
   output logic [15:0]                  ts_count
);

   localparam logic [NEURON_ADDR_WIDTH-1:0] LAST_ADDR = NEURON_ADDR_WIDTH'(NUM_NEURONS - 1);

   l2s_state_e                   state_q, state_d;
   logic [NEURON_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [NEURON_ADDR_WIDTH-1:0] idx_q;
   logic                         done_q, done_d;
   logic                         spike_q, spike_d;
   logic [WIDTH-1:0]             cur_q, cur_d;
   logic [15:0]                  ts_q, ts_d;
   logic                         load_rec;
   logic [8:0]                   centered;

`ifdef L2S_THRESHOLD_MODE_EN
   // Deterministic spike: upper half of the gray range fires.
   always_comb begin
      spike_d = (fb_rdata >= 8'd128);
   end
`else
   logic [15:0] lfsr_q;
   logic        lfsr_adv;
   logic        unused_lfsr_hi;

   // Advance once per accepted record so the sequence is independent of stalls.
   assign lfsr_adv       = (state_q == StEmit) & out_ready;
   // Only the low byte feeds the comparison.
   assign unused_lfsr_hi = ^lfsr_q[15:8];

   l2s_lfsr16 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .seed  (LFSR_SEED),
      .adv   (lfsr_adv),
      .q     (lfsr_q)
   );

   // Stochastic spike: probability tracks gray level; full white always fires.
   always_comb begin
      spike_d = (fb_rdata == 8'hFF) | (fb_rdata > lfsr_q[7:0]);
   end
`endif

   // Current: (gray - 128) as signed 9-bit, sign-extended, scaled by 2^(FRAC-4).
   always_comb begin
      centered = {1'b0, fb_rdata} - GRAY_BIAS;
      cur_d    = {{(WIDTH - 9){centered[8]}}, centered} << (FRAC - 4);
   end

   // Next-state logic for the scan FSM.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      done_d   = 1'b0;
      ts_d     = ts_q;
      load_rec = 1'b0;
      unique case (state_q)
         StIdle: begin
            // done_q marks the cycle right after the last handshake; start is ignored there.
            if (start && !done_q) begin
               addr_d  = '0;
               state_d = StRead;
            end
         end
         StRead: begin
            state_d = StWait;
         end
         StWait: begin
            load_rec = 1'b1;
            state_d  = StEmit;
         end
         StEmit: begin
            if (out_ready) begin
               if (addr_q == LAST_ADDR) begin
                  done_d  = 1'b1;
                  ts_d    = ts_q + 16'd1;
                  state_d = StIdle;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = StRead;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and record registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         done_q  <= 1'b0;
         ts_q    <= '0;
         idx_q   <= '0;
         spike_q <= 1'b0;
         cur_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         ts_q    <= ts_d;
         if (load_rec) begin
            idx_q   <= addr_q;
            spike_q <= spike_d;
            cur_q   <= cur_d;
         end
      end
   end

   assign busy        = (state_q != StIdle);
   assign fb_re       = (state_q == StRead);
   assign out_valid   = (state_q == StEmit);
   assign fb_addr     = addr_q;
   assign done        = done_q;
   assign spike_valid = spike_q;
   assign neuron_idx  = idx_q;
   assign i_out       = cur_q;
   assign ts_count    = ts_q;

endmodule
